// File: rtl/request_stager.sv
// rtl/request_stager.sv - two-client command stager feeding a request/grant arbiter and a shared burst bus
// Optional request-timeout flags are built only when REQ_TIMEOUT_EN is defined.
module request_stager #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c0_valid,
    output logic              c0_ready,
    input  logic [DATA_W-1:0] c0_data,
    input  logic [LEN_W-1:0]  c0_len,
    input  logic              c1_valid,
    output logic              c1_ready,
    input  logic [DATA_W-1:0] c1_data,
    input  logic [LEN_W-1:0]  c1_len,
    output logic              R0,
    output logic              R1,
    input  logic              G0,
    input  logic              G1,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_src,
    output logic              bus_last,
    output logic              grant_err,
    output logic [1:0]        timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + LEN_W;

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    logic [1:0]              in_valid;
    logic [1:0][DATA_W-1:0]  in_data;
    logic [1:0][LEN_W-1:0]   in_len;
    logic [1:0]              ready;
    logic [1:0]              req;
    logic [1:0]              gnt_ok;
    logic [1:0]              beat;
    logic [1:0]              beat_last;
    logic [1:0][DATA_W-1:0]  beat_data;

    assign in_valid = {c1_valid, c0_valid};
    assign in_data  = {c1_data, c0_data};
    assign in_len   = {c1_len, c0_len};
    assign c0_ready = ready[0];
    assign c1_ready = ready[1];
    assign R0       = req[0];
    assign R1       = req[1];

    // A grant is honoured only when it is the sole grant; G0&G1 freezes both channels.
    assign gnt_ok[0] = G0 & ~G1;
    assign gnt_ok[1] = G1 & ~G0;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        state_t            state, state_next;
        logic [EW-1:0]     mem [DEPTH];
        logic [AW-1:0]     wptr, rptr;
        logic [AW:0]       count;
        logic              push, pop, non_empty;
        logic [DATA_W-1:0] wdata;
        logic [LEN_W-1:0]  wlen, cnt;

        // ready comes from the registered count, so a pop on a full FIFO frees space only next cycle
        assign ready[g]     = (count != (AW+1)'(DEPTH));
        assign push         = in_valid[g] & ready[g];
        assign non_empty    = (count != '0);
        assign pop          = (state == REQ) & gnt_ok[g];
        assign req[g]       = (state == REQ) | (state == XFER);
        assign beat[g]      = (state == XFER) & gnt_ok[g];
        assign beat_last[g] = (cnt == wlen);
        assign beat_data[g] = wdata + DATA_W'(cnt);

        always_ff @(posedge clock) begin
            if (push) mem[wptr] <= {in_len[g], in_data[g]};
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) state <= IDLE;
            else        state <= state_next;
        end

        always_comb begin
            state_next = state;
            case (state)
                IDLE:    if (non_empty) state_next = REQ;
                REQ:     if (gnt_ok[g]) state_next = XFER;
                XFER:    if (beat[g] && beat_last[g]) state_next = GAP;
                GAP:     state_next = non_empty ? REQ : IDLE;
                default: state_next = IDLE;
            endcase
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                wdata <= '0;
                wlen  <= '0;
                cnt   <= '0;
            end else if (pop) begin
                wdata <= mem[rptr][DATA_W-1:0];
                wlen  <= mem[rptr][EW-1:DATA_W];
                cnt   <= '0;
            end else if (beat[g] && !beat_last[g]) begin
                cnt <= cnt + 1'b1;
            end
        end

`ifdef REQ_TIMEOUT_EN
        localparam int TW = $clog2(TIMEOUT + 1);
        logic [TW-1:0] wait_cnt;
        logic          to_flag;

        always_ff @(posedge clock) begin
            if (!reset) begin
                wait_cnt <= '0;
                to_flag  <= 1'b0;
            end else if (state == REQ && !gnt_ok[g]) begin
                if (wait_cnt != TW'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= TW'(TIMEOUT - 1)) to_flag <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
        assign timeout[g] = to_flag;
`else
        assign timeout[g] = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus_valid <= 1'b0;
            bus_data  <= '0;
            bus_src   <= 1'b0;
            bus_last  <= 1'b0;
        end else begin
            bus_valid <= |beat;
            bus_last  <= 1'b0;
            if (beat[0]) begin
                bus_data <= beat_data[0];
                bus_src  <= 1'b0;
                bus_last <= beat_last[0];
            end else if (beat[1]) begin
                bus_data <= beat_data[1];
                bus_src  <= 1'b1;
                bus_last <= beat_last[1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)        grant_err <= 1'b0;
        else if (G0 && G1) grant_err <= 1'b1;
    end
endmodule

// File: tb/tb_request_stager.sv
// tb/tb_request_stager.sv - scoreboard bench for request_stager (REQ_TIMEOUT_EN selects the timeout case)
module tb_request_stager;
    logic       clock = 1'b0;
    logic       reset;
    logic       c0_valid, c1_valid;
    logic       c0_ready, c1_ready;
    logic [7:0] c0_data, c1_data;
    logic [2:0] c0_len, c1_len;
    logic       R0, R1, G0, G1;
    logic       bus_valid, bus_src, bus_last, grant_err;
    logic [7:0] bus_data;
    logic [1:0] timeout;

    typedef struct packed {
        logic       src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  arb_en = 1'b0;
    int    holder = 2;
    int    last_gnt = 1;

    request_stager dut (
        .clock(clock), .reset(reset),
        .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_data(c0_data), .c0_len(c0_len),
        .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_data(c1_data), .c1_len(c1_len),
        .R0(R0), .R1(R1), .G0(G0), .G1(G1),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_src(bus_src), .bus_last(bus_last),
        .grant_err(grant_err), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_beat(input logic src, input logic [7:0] data, input logic last);
        beat_t b;
        b.src = src; b.data = data; b.last = last;
        sb.push_back(b);
    endtask

    task automatic push(input int ch, input logic [7:0] d, input logic [2:0] len);
        if (ch == 0) begin c0_valid = 1'b1; c0_data = d; c0_len = len; end
        else         begin c1_valid = 1'b1; c1_data = d; c1_len = len; end
        @(negedge clock);
        c0_valid = 1'b0;
        c1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_drained"}, sb.size(), 0);
        repeat (4) @(negedge clock);
        chk({name, "_idle_R0"}, R0, 0);
        chk({name, "_idle_R1"}, R1, 0);
    endtask

    // Monitor: every bus beat must match the oldest expected beat.
    always @(negedge clock) begin
        if (reset === 1'b1 && bus_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=src%0d:%0h:last%0d expected=none", bus_src, bus_data, bus_last);
            end else begin
                beat_t e;
                e = sb.pop_front();
                if ({bus_src, bus_data, bus_last} !== e) begin
                    errors++;
                    $display("FAIL beat actual=src%0d:%0h:last%0d expected=src%0d:%0h:last%0d",
                             bus_src, bus_data, bus_last, e.src, e.data, e.last);
                end
            end
        end
    end

    // Arbiter model: hold the grant while its requester stays up, otherwise alternate.
    always @(negedge clock) begin
        if (arb_en) begin
            if (!((holder == 0 && R0) || (holder == 1 && R1))) begin
                if (R0 && (!R1 || last_gnt == 1))  begin holder = 0; last_gnt = 0; end
                else if (R1)                        begin holder = 1; last_gnt = 1; end
                else                                holder = 2;
            end
            G0 = (holder == 0);
            G1 = (holder == 1);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n, low;
        reset = 1'b0; G0 = 1'b0; G1 = 1'b0;
        c0_valid = 1'b1; c0_data = 8'h55; c0_len = 3'd1;
        c1_valid = 1'b0; c1_data = 8'h00; c1_len = 3'd0;
        repeat (3) @(negedge clock);
        chk("rst_R0", R0, 0);
        chk("rst_R1", R1, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_c0_ready", c0_ready, 1);
        chk("rst_grant_err", grant_err, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b1; c0_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_fifo_empty_R0", R0, 0);

        // Single burst followed by a len=0 burst; R0 must drop for exactly one cycle between them
        push(0, 8'h10, 3'd2);
        push(0, 8'h20, 3'd0);
        expect_beat(0, 8'h10, 0); expect_beat(0, 8'h11, 0); expect_beat(0, 8'h12, 1);
        expect_beat(0, 8'h20, 1);
        G0 = 1'b1;
        low = 0; n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock); #1;
            n++;
            if (sb.size() != 0 && !R0) low++;
        end
        chk("gap_R0_low_cycles", low, 1);
        drain("single");
        G0 = 1'b0;

        // Fill client 1 without grants; fifth push is dropped
        for (int i = 0; i < 5; i++) begin
            c1_valid = 1'b1;
            c1_data  = 8'h30 + 8'(i * 16);
            c1_len   = (i == 1) ? 3'd1 : 3'd0;
            chk($sformatf("fill_ready_%0d", i), c1_ready, (i < 4) ? 1 : 0);
            @(negedge clock);
        end
        c1_valid = 1'b0;
        expect_beat(1, 8'h30, 1); expect_beat(1, 8'h40, 0); expect_beat(1, 8'h41, 1);
        expect_beat(1, 8'h50, 1); expect_beat(1, 8'h60, 1);
        repeat (2) @(negedge clock);
        chk("fill_R1", R1, 1);
        chk("fill_ready_full", c1_ready, 0);
        // Push coinciding with the first pop of a full FIFO must be ignored
        c1_valid = 1'b1; c1_data = 8'h77; c1_len = 3'd0; G1 = 1'b1;
        chk("full_pushpop_ready", c1_ready, 0);
        @(negedge clock);
        c1_valid = 1'b0;
        chk("after_pop_ready", c1_ready, 1);
        drain("fill");
        G1 = 1'b0;

        // Alternation with both FIFOs loaded
        c0_valid = 1'b1; c0_data = 8'h80; c0_len = 3'd1;
        c1_valid = 1'b1; c1_data = 8'h90; c1_len = 3'd1;
        @(negedge clock);
        c0_data = 8'hA0; c0_len = 3'd0;
        c1_data = 8'hB0; c1_len = 3'd2;
        @(negedge clock);
        c0_valid = 1'b0; c1_valid = 1'b0;
        expect_beat(0, 8'h80, 0); expect_beat(0, 8'h81, 1);
        expect_beat(1, 8'h90, 0); expect_beat(1, 8'h91, 1);
        expect_beat(0, 8'hA0, 1);
        expect_beat(1, 8'hB0, 0); expect_beat(1, 8'hB1, 0); expect_beat(1, 8'hB2, 1);
        holder = 2; last_gnt = 1; arb_en = 1'b1;
        drain("alternate");
        arb_en = 1'b0; G0 = 1'b0; G1 = 1'b0;

        // Stall, double grant, and data wrap at 8'hFF
        push(0, 8'hFE, 3'd3);
        expect_beat(0, 8'hFE, 0); expect_beat(0, 8'hFF, 0);
        expect_beat(0, 8'h00, 0); expect_beat(0, 8'h01, 1);
        repeat (2) @(negedge clock);
        G0 = 1'b1;
        n = 0;
        while (bus_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("stall_first_beat_seen", bus_valid, 1);
        G0 = 1'b0;
        @(negedge clock);
        chk("stall_no_beat_1", bus_valid, 0);
        @(negedge clock);
        chk("stall_no_beat_2", bus_valid, 0);
        chk("stall_R0_held", R0, 1);
        G0 = 1'b1; G1 = 1'b1;
        @(negedge clock);
        chk("dual_grant_no_beat", bus_valid, 0);
        chk("dual_grant_err", grant_err, 1);
        G1 = 1'b0;
        drain("stall");
        G0 = 1'b0;
        chk("grant_err_sticky", grant_err, 1);

`ifdef REQ_TIMEOUT_EN
        push(0, 8'h05, 3'd0);
        expect_beat(0, 8'h05, 1);
        repeat (20) @(negedge clock);
        chk("timeout_set", timeout, 2'b01);
        chk("timeout_R0_held", R0, 1);
        G0 = 1'b1;
        drain("timeout");
        G0 = 1'b0;
        chk("timeout_sticky", timeout, 2'b01);
`else
        push(0, 8'h05, 3'd0);
        expect_beat(0, 8'h05, 1);
        repeat (20) @(negedge clock);
        chk("no_timeout", timeout, 2'b00);
        G0 = 1'b1;
        drain("timeout");
        G0 = 1'b0;
`endif

        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rst2_grant_err", grant_err, 0);
        chk("rst2_timeout", timeout, 0);
        chk("rst2_bus_valid", bus_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
